// File: rtl/bk_subtractor_pipe.sv
// Pipelined Brent-Kung subtractor: res = data1 - data2 - borrow_in over three
// registered stages (operand prep, prefix up-sweep, down-sweep plus flags).
module bk_subtractor_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
);
    localparam int LEVELS = $clog2(WIDTH);

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    // A stage advances when it is empty or its downstream neighbour advances.
    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    logic [WIDTH-1:0] p_in, g_in, g_fold;
    logic             cin_in;

    assign cin_in = ~borrow_in;
    assign p_in   = data1 ^ ~data2;
    assign g_in   = data1 & ~data2;
    assign g_fold = {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & cin_in)};

    logic [WIDTH-1:0] p1, g1;
    logic             cin1, sa1, sb1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            p1   <= '0;
            g1   <= '0;
            cin1 <= 1'b0;
            sa1  <= 1'b0;
            sb1  <= 1'b0;
        end else if (adv1) begin
            v1   <= in_valid;
            p1   <= p_in;
            g1   <= g_fold;
            cin1 <= cin_in;
            sa1  <= data1[WIDTH-1];
            sb1  <= data2[WIDTH-1];
        end
    end

    logic [WIDTH-1:0] g_up, p_up;

    // Up-sweep: at level l, node i (every 2^l-th bit) absorbs the group below it.
    always_comb begin
        g_up = g1;
        p_up = p1;
        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    g_up[i] = g_up[i] | (p_up[i] & g_up[i - (1 << (l - 1))]);
                    p_up[i] = p_up[i] & p_up[i - (1 << (l - 1))];
                end
            end
        end
    end

    logic [WIDTH-1:0] g2, pp2, p2;
    logic             cin2, sa2, sb2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            g2   <= '0;
            pp2  <= '0;
            p2   <= '0;
            cin2 <= 1'b0;
            sa2  <= 1'b0;
            sb2  <= 1'b0;
        end else if (adv2) begin
            v2   <= v1;
            g2   <= g_up;
            pp2  <= p_up;
            p2   <= p1;
            cin2 <= cin1;
            sa2  <= sa1;
            sb2  <= sb1;
        end
    end

    logic [WIDTH-1:0] g_dn, res_n;
    logic [WIDTH:0]   carries;
    logic             borrow_n, ovf_n, zero_n;

    // Down-sweep fills in the carries the up-sweep skipped, finest level last.
    always_comb begin
        g_dn = g2;
        for (int l = LEVELS - 1; l >= 1; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l) && ((i + 1 - (1 << (l - 1))) % (1 << l)) == 0) begin
                    g_dn[i] = g_dn[i] | (pp2[i] & g_dn[i - (1 << (l - 1))]);
                end
            end
        end
    end

    assign carries  = {g_dn, cin2};
    assign res_n    = p2 ^ carries[WIDTH-1:0];
    assign borrow_n = ~carries[WIDTH];
    assign ovf_n    = (sa2 != sb2) && (res_n[WIDTH-1] != sa2);
    assign zero_n   = (res_n == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3         <= 1'b0;
            res        <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
        end else if (adv3) begin
            v3         <= v2;
            res        <= res_n;
            borrow_out <= borrow_n;
            ovf        <= ovf_n;
            zero       <= zero_n;
        end
    end

endmodule
